// File: rtl/cpu_pkg.sv
// Shared CPU-side constants (RAM geometry) and the program loader state encoding.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;
endpackage

// File: rtl/ram_loader_if.sv
// Loader byte stream in (rx_*) and RAM write port out (ram_*); slave side is the loader.
interface ram_loader_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_sel;

  modport master (output rx_data, rx_valid, input ram_addr, ram_data, ram_sel);
  modport slave  (input rx_data, rx_valid, output ram_addr, ram_data, ram_sel);
endinterface

// File: rtl/ram_loader.sv
// Length-prefixed image loader filling RAM 0..N-1 while holding the CPU in halt.
// RAM_LOADER_CHECKSUM_EN adds a trailing 8-bit additive checksum byte and the error path.
module ram_loader
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  ram_loader_if.slave  bus,
  output logic         cpu_halt,
  output logic         done,
  output logic         error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              error_q, error_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
`ifdef RAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      error_q <= error_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = 1'b0;
    halt_d  = halt_q;
    done_d  = done_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    error_d = error_q;
`endif
    case (state_q)
      // Bytes arriving while parked (even alongside start) are deliberately dropped.
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN;
          halt_d  = 1'b1;
          done_d  = 1'b0;
          count_d = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          error_d = 1'b0;
`endif
        end
      end
      LEN: begin
        if (bus.rx_valid) begin
          len_d   = (bus.rx_data == '0) ? LEN_MAX : CNT_W'(bus.rx_data);
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          sel_d   = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = bus.rx_data;
          count_d = count_q + CNT_ONE;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + bus.rx_data;
`endif
          if ((count_q + CNT_ONE) == len_q) begin
`ifdef RAM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
`endif
          end
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            halt_d  = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.ram_sel  = sel_q;
  assign cpu_halt     = halt_q;
  assign done         = done_q;
`ifdef RAM_LOADER_CHECKSUM_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: images are checked against a RAM/flag model built from the framing rules.
module tb_ram_loader;
  import cpu_pkg::*;

`ifdef RAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_halt, done, error;
  logic clr_cnt;

  always #5 clk = ~clk;

  ram_loader_if bus ();

  ram_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_halt (cpu_halt),
    .done     (done),
    .error    (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural RAM plus write-port activity counters
  logic [7:0] ram [256];
  int         sel_cnt, run_cur, run_max;
  logic [7:0] last_addr;

  always @(posedge clk) begin
    if (clr_cnt) begin
      sel_cnt <= 0;
      run_cur <= 0;
      run_max <= 0;
      for (int i = 0; i < 256; i++) ram[i] <= 'x;
    end else if (bus.ram_sel) begin
      ram[bus.ram_addr] <= bus.ram_data;
      sel_cnt   <= sel_cnt + 1;
      run_cur   <= run_cur + 1;
      if (run_cur + 1 > run_max) run_max <= run_cur + 1;
      last_addr <= bus.ram_addr;
    end else begin
      run_cur <= 0;
    end
  end

  // Reference model state
  logic [7:0] img [$];
  logic [7:0] exp_mem [256];
  int         exp_n;
  logic       exp_done, exp_err;

  task automatic model();
    logic [7:0] s;
    s = 8'h00;
    exp_n = (img[0] == 8'h00) ? 256 : int'(img[0]);
    for (int i = 0; i < exp_n; i++) begin
      exp_mem[i] = img[1 + i];
      s = s + img[1 + i];
    end
    if (CSUM_EN) begin
      exp_err  = (img[1 + exp_n] != s);
      exp_done = !exp_err;
    end else begin
      exp_err  = 1'b0;
      exp_done = 1'b1;
    end
  endtask

  task automatic make_image(input int len_field, input bit corrupt);
    logic [7:0] s, b;
    int n;
    s = 8'h00;
    n = (len_field == 0) ? 256 : len_field;
    img.delete();
    img.push_back(8'(len_field));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      img.push_back(b);
      s = s + b;
    end
    if (CSUM_EN) img.push_back(corrupt ? (s ^ 8'(1 + $urandom_range(254, 0))) : s);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start   = 1'b1;
    clr_cnt = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic stream_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      send(img[i]);
      if (i < last) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  // Drives one full load and samples the flags in the first cycle after the terminating byte.
  task automatic run_load(input int max_gap, output logic o_arm, output logic o_done,
                          output logic o_err, output logic o_halt, output logic o_sel,
                          output int o_cnt, output int o_bad);
    pulse_start();
    o_arm = cpu_halt;
    stream_range(0, img.size() - 1, max_gap);
    o_done = done;
    o_err  = error;
    o_halt = cpu_halt;
    o_sel  = bus.ram_sel;
    @(negedge clk);
    o_cnt = sel_cnt;
    o_bad = 0;
    for (int i = 0; i < exp_n; i++) if (ram[i] !== exp_mem[i]) o_bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clr_cnt = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ram_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", bus.ram_addr); else n_pass++;
    n_checks++; if (bus.ram_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.ram_data); else n_pass++;
    n_checks++; if (bus.ram_sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", bus.ram_sel); else n_pass++;
    n_checks++; if (cpu_halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", cpu_halt); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_with_byte();
    logic o_done, o_err, o_halt;
    int o_bad, o_cnt;
    make_image(6, 1'b0);
    model();
    start = 1'b1; clr_cnt = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h03;
    @(negedge clk);
    start = 1'b0; clr_cnt = 1'b0; bus.rx_valid = 1'b0;
    stream_range(0, img.size() - 1, 0);
    o_done = done; o_err = error; o_halt = cpu_halt;
    @(negedge clk);
    o_cnt = sel_cnt;
    o_bad = 0;
    for (int i = 0; i < exp_n; i++) if (ram[i] !== exp_mem[i]) o_bad++;
    n_checks++; if (o_done !== 1'b1) $display("FAIL swb_done: got %b want 1", o_done); else n_pass++;
    n_checks++; if (o_cnt !== exp_n) $display("FAIL swb_writes: got %0d want %0d", o_cnt, exp_n); else n_pass++;
    n_checks++; if (o_bad !== 0) $display("FAIL swb_mem: got %0d bad bytes want 0", o_bad); else n_pass++;
  endtask

  task automatic test_basic();
    logic o_arm, o_done, o_err, o_halt, o_sel;
    int o_cnt, o_bad;
    img = '{8'h03, 8'h11, 8'h22, 8'h33};
    if (CSUM_EN) img.push_back(8'h66);
    model();
    run_load(0, o_arm, o_done, o_err, o_halt, o_sel, o_cnt, o_bad);
    n_checks++; if (o_arm !== 1'b1) $display("FAIL basic_halt_arm: got %b want 1", o_arm); else n_pass++;
    n_checks++; if (o_done !== 1'b1) $display("FAIL basic_done: got %b want 1", o_done); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL basic_error: got %b want 0", o_err); else n_pass++;
    n_checks++; if (o_halt !== 1'b0) $display("FAIL basic_halt: got %b want 0", o_halt); else n_pass++;
    n_checks++; if (o_sel !== !CSUM_EN) $display("FAIL basic_last_sel: got %b want %b", o_sel, !CSUM_EN); else n_pass++;
    n_checks++; if (o_cnt !== 3) $display("FAIL basic_writes: got %0d want 3", o_cnt); else n_pass++;
    n_checks++; if (run_max !== 3) $display("FAIL basic_run: got %0d want 3", run_max); else n_pass++;
    n_checks++; if (o_bad !== 0) $display("FAIL basic_mem: got %0d bad bytes want 0", o_bad); else n_pass++;
  endtask

  task automatic test_csum_error();
`ifdef RAM_LOADER_CHECKSUM_EN
    logic o_arm, o_done, o_err, o_halt, o_sel;
    int o_cnt, o_bad;
    img = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h67};
    model();
    run_load(0, o_arm, o_done, o_err, o_halt, o_sel, o_cnt, o_bad);
    n_checks++; if (o_err !== 1'b1) $display("FAIL cerr_error: got %b want 1", o_err); else n_pass++;
    n_checks++; if (o_halt !== 1'b1) $display("FAIL cerr_halt: got %b want 1", o_halt); else n_pass++;
    n_checks++; if (o_done !== 1'b0) $display("FAIL cerr_done: got %b want 0", o_done); else n_pass++;
    n_checks++; if (o_cnt !== 3) $display("FAIL cerr_writes: got %0d want 3", o_cnt); else n_pass++;
`endif
  endtask

  task automatic test_full();
    logic o_arm, o_done, o_err, o_halt, o_sel;
    int o_cnt, o_bad;
    img.delete();
    img.push_back(8'h00);
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    if (CSUM_EN) img.push_back(8'h80);
    model();
    run_load(0, o_arm, o_done, o_err, o_halt, o_sel, o_cnt, o_bad);
    n_checks++; if (o_done !== 1'b1) $display("FAIL full_done: got %b want 1", o_done); else n_pass++;
    n_checks++; if (o_cnt !== 256) $display("FAIL full_writes: got %0d want 256", o_cnt); else n_pass++;
    n_checks++; if (last_addr !== 8'hFF) $display("FAIL full_last_addr: got %h want ff", last_addr); else n_pass++;
    n_checks++; if (o_bad !== 0) $display("FAIL full_mem: got %0d bad bytes want 0", o_bad); else n_pass++;
  endtask

  task automatic test_start_mid();
    int o_bad;
    make_image(10, 1'b0);
    model();
    pulse_start();
    stream_range(0, 4, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stream_range(5, img.size() - 1, 1);
    n_checks++; if (done !== 1'b1) $display("FAIL smid_done: got %b want 1", done); else n_pass++;
    @(negedge clk);
    o_bad = 0;
    for (int i = 0; i < exp_n; i++) if (ram[i] !== exp_mem[i]) o_bad++;
    n_checks++; if (sel_cnt !== exp_n) $display("FAIL smid_writes: got %0d want %0d", sel_cnt, exp_n); else n_pass++;
    n_checks++; if (o_bad !== 0) $display("FAIL smid_mem: got %0d bad bytes want 0", o_bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic o_arm, o_done, o_err, o_halt, o_sel;
    int o_cnt, o_bad;
    pulse_start();
    send(8'h04);
    send(8'hAA);
    send(8'hBB);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ram_sel !== 1'b0) $display("FAIL rmid_sel: got %b want 0", bus.ram_sel); else n_pass++;
    n_checks++; if (bus.ram_addr !== 8'h00) $display("FAIL rmid_addr: got %h want 00", bus.ram_addr); else n_pass++;
    n_checks++; if (bus.ram_data !== 8'h00) $display("FAIL rmid_data: got %h want 00", bus.ram_data); else n_pass++;
    n_checks++; if (cpu_halt !== 1'b0) $display("FAIL rmid_halt: got %b want 0", cpu_halt); else n_pass++;
    n_checks++; if ({done, error} !== 2'b00) $display("FAIL rmid_flags: got %b want 00", {done, error}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    make_image(int'($urandom_range(30, 5)), 1'b0);
    model();
    run_load(2, o_arm, o_done, o_err, o_halt, o_sel, o_cnt, o_bad);
    n_checks++; if (o_done !== 1'b1) $display("FAIL rmid_reload_done: got %b want 1", o_done); else n_pass++;
    n_checks++; if (o_bad !== 0) $display("FAIL rmid_reload_mem: got %0d bad bytes want 0", o_bad); else n_pass++;
  endtask

  task automatic test_random_gaps();
    logic o_arm, o_done, o_err, o_halt, o_sel;
    int o_cnt, o_bad;
    for (int k = 0; k < 5; k++) begin
      make_image(int'($urandom_range(40, 1)), CSUM_EN && ($urandom_range(2, 0) == 0));
      model();
      run_load(5, o_arm, o_done, o_err, o_halt, o_sel, o_cnt, o_bad);
      n_checks++; if (o_done !== exp_done) $display("FAIL gaps%0d_done: got %b want %b", k, o_done, exp_done); else n_pass++;
      n_checks++; if (o_err !== exp_err) $display("FAIL gaps%0d_error: got %b want %b", k, o_err, exp_err); else n_pass++;
      n_checks++; if (o_halt !== !exp_done) $display("FAIL gaps%0d_halt: got %b want %b", k, o_halt, !exp_done); else n_pass++;
      n_checks++; if (o_cnt !== exp_n) $display("FAIL gaps%0d_writes: got %0d want %0d", k, o_cnt, exp_n); else n_pass++;
      n_checks++; if (o_bad !== 0) $display("FAIL gaps%0d_mem: got %0d bad bytes want 0", k, o_bad); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_with_byte();
    test_basic();
    test_csum_error();
    test_full();
    test_start_mid();
    test_reset_mid();
    test_random_gaps();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
